// File: rtl/spi_adc_pkg.sv
// Shared types and helpers for the multi-channel SPI ADC sampler.
package spi_adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_PUSH = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Channel tag width: at least one bit even for a single channel
    function automatic int unsigned calc_chw(input int unsigned n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_N_CH   = 2;
    localparam int unsigned DEF_CHW    = calc_chw(DEF_N_CH);

    // Tagged FIFO word as seen by consumers of the default configuration
    typedef struct packed {
        logic [DEF_CHW-1:0]    ch;
        logic [DEF_DATA_W-1:0] sample;
    } tagged_word_t;

endpackage

// File: rtl/spi_adc_mc_fifo_fifo.sv
// First-word-fall-through synchronous FIFO with fill count.
module tagged_sync_fifo #(
    parameter  int unsigned WIDTH = 9,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_c, do_pop_c;

    // Pointer and count update; pushes when full and pops when empty are ignored
    always_comb begin
        do_push_c = push && (count_q != CW'(DEPTH));
        do_pop_c  = pop && (count_q != '0);
        wr_ptr_d  = do_push_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = do_pop_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q;
        if (do_push_c && !do_pop_c) begin
            count_d = count_q + CW'(1);
        end else if (!do_push_c && do_pop_c) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointer/count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; cleared on reset so the head word reads zero while empty after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_c) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;

endmodule

// File: rtl/spi_adc_mc_fifo.sv
// Multi-channel SPI ADC sampler: shared cs_n/sclk, parallel capture, tagged FIFO push.
module spi_adc_mc_fifo
    import spi_adc_pkg::*;
#(
    parameter  int unsigned DATA_W      = 8,
    parameter  int unsigned N_CH        = 2,
    parameter  int unsigned FIFO_DEPTH  = 16,
    parameter  int unsigned CLK_DIV     = 4,
    parameter  int unsigned AUTO_PERIOD = 256,
    localparam int unsigned CHW         = calc_chw(N_CH),
    localparam int unsigned CW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_sample,
    input  logic                  auto_en,
    input  logic [N_CH-1:0]       din,
    input  logic                  fifo_pop,
    input  logic                  clr_ovf,
    output logic                  cs_n,
    output logic                  sclk,
    output logic                  busy,
    output logic                  done,
    output logic [CHW+DATA_W-1:0] fifo_dout,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic [CW-1:0]         fifo_count,
    output logic                  overflow
);
    localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W  = $clog2(DATA_W) + 1;
    localparam int unsigned AUTO_W = $clog2(AUTO_PERIOD) + 1;

    typedef struct packed {
        logic [CHW-1:0]    ch;
        logic [DATA_W-1:0] sample;
    } word_t;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [CHW-1:0]    ch_q, ch_d;
    logic [AUTO_W-1:0] auto_q, auto_d;
    logic              cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] shreg_q [N_CH];
    logic [DATA_W-1:0] shreg_d [N_CH];
    logic              auto_tick_c;
    logic              space_ok_c;
    logic              push_c;
    word_t             push_word_c;

    // Next-state, sclk divider, capture, push sequencing, auto trigger and overflow
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        ch_d        = ch_q;
        cs_n_d      = cs_n_q;
        sclk_d      = sclk_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ovf_d       = ovf_q;
        shreg_d     = shreg_q;
        push_c      = 1'b0;
        auto_tick_c = auto_en && (auto_q == AUTO_W'(AUTO_PERIOD - 1));
        space_ok_c  = (CW'(FIFO_DEPTH) - fifo_count) >= CW'(N_CH);
        push_word_c.ch     = ch_q;
        push_word_c.sample = shreg_q[ch_q];

        if (!auto_en || auto_tick_c) begin
            auto_d = '0;
        end else begin
            auto_d = auto_q + AUTO_W'(1);
        end

        // A drop later in this block overrides the clear
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                div_d = '0;
                bit_d = '0;
                ch_d  = '0;
                if (start_sample || auto_tick_c) begin
                    state_d = ST_CONV;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_CONV: begin
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d  = '0;
                    sclk_d = !sclk_q;
                    if (!sclk_q) begin
                        for (int i = 0; i < int'(N_CH); i++) begin
                            shreg_d[i] = DATA_W'({shreg_q[i], din[i]});
                        end
                    end else if (bit_q == BIT_W'(DATA_W - 1)) begin
                        state_d = ST_PUSH;
                        cs_n_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_PUSH: begin
                // Space is checked once, on entry; later pops only free more room
                if ((ch_q == '0) && !space_ok_c) begin
                    ovf_d   = 1'b1;
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    push_c = 1'b1;
                    if (ch_q == CHW'(N_CH - 1)) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        ch_d = ch_q + CHW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            ch_q    <= '0;
            auto_q  <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < int'(N_CH); i++) begin
                shreg_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            ch_q    <= ch_d;
            auto_q  <= auto_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            shreg_q <= shreg_d;
        end
    end

    tagged_sync_fifo #(
        .WIDTH (CHW + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .din   (push_word_c),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign cs_n     = cs_n_q;
    assign sclk     = sclk_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule
